wb_arbiter_2m: RTL



---
 rtl/wb_arbiter_2m.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter with round-robin grant held for
// the whole cyc, plus a watchdog that aborts an unanswered strobe with err.
// Handshake: a master owns the slave from the cycle after its cyc is seen
// until it drops cyc; each stb beat is ended by one of ack/err/rty from the
// slave, or by a one-cycle err from the arbiter when the watchdog expires.
module wb_arbiter_2m #(
   parameter int TIMEOUT = 1000,
   parameter int CNT_W   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m0_adr,
   input  logic [7:0]  m0_dout,
   input  logic        m0_cyc,
   input  logic        m0_stb,
   input  logic        m0_we,
   input  logic        m0_sel,
   output logic [7:0]  m0_din,
   output logic        m0_ack,
   output logic        m0_err,
   output logic        m0_rty,
   input  logic [31:0] m1_adr,
   input  logic [7:0]  m1_dout,
   input  logic        m1_cyc,
   input  logic        m1_stb,
   input  logic        m1_we,
   input  logic        m1_sel,
   output logic [7:0]  m1_din,
   output logic        m1_ack,
   output logic        m1_err,
   output logic        m1_rty,
   output logic [31:0] s_adr,
   output logic [7:0]  s_dout,
   output logic        s_cyc,
   output logic        s_stb,
   output logic        s_we,
   output logic        s_sel,
   input  logic [7:0]  s_din,
   input  logic        s_ack,
   input  logic        s_err,
   input  logic        s_rty,
   output logic [1:0]  gnt,
   output logic [7:0]  to_cnt,
   output logic        to_flag
);

   typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, ABORT} state_t;

   // Last watchdog value before expiry; the cycle that brings the count to
   // TIMEOUT without a termination triggers the abort.
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] WD_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic             last_q, last_d;      // 1 = m1 was granted last
   logic [CNT_W-1:0] wd_q, wd_d;
   logic [7:0]       to_cnt_q, to_cnt_d;
   logic             to_flag_q, to_flag_d;

   // last_q always names the owner while in BUSYx/ABORT, so it doubles as
   // the master-side mux select.
   logic        g_cyc, g_stb, g_we, g_sel;
   logic [31:0] g_adr;
   logic [7:0]  g_dout;
   logic        s_term;

   assign g_cyc  = last_q ? m1_cyc  : m0_cyc;
   assign g_stb  = last_q ? m1_stb  : m0_stb;
   assign g_we   = last_q ? m1_we   : m0_we;
   assign g_sel  = last_q ? m1_sel  : m0_sel;
   assign g_adr  = last_q ? m1_adr  : m0_adr;
   assign g_dout = last_q ? m1_dout : m0_dout;
   assign s_term = s_ack | s_err | s_rty;

   assign to_cnt  = to_cnt_q;
   assign to_flag = to_flag_q;

   // State, round-robin history, watchdog and timeout statistics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         wd_q      <= '0;
         to_cnt_q  <= 8'd0;
         to_flag_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         wd_q      <= wd_d;
         to_cnt_q  <= to_cnt_d;
         to_flag_q <= to_flag_d;
      end
   end

   // Next-state: arbitration in IDLE, release/watchdog in BUSY, abort bookkeeping.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      wd_d      = '0;
      to_cnt_d  = to_cnt_q;
      to_flag_d = to_flag_q;
      case (state_q)
         IDLE: begin
            if (m0_cyc && (!m1_cyc || last_q)) begin
               state_d = BUSY0;
               last_d  = 1'b0;
            end else if (m1_cyc) begin
               state_d = BUSY1;
               last_d  = 1'b1;
            end
         end
         BUSY0, BUSY1: begin
            if (!g_cyc) begin
               state_d = IDLE;
            end else if (g_stb && !s_term) begin
               if (wd_q >= WD_LAST) state_d = ABORT;
               else                 wd_d    = wd_q + WD_ONE;
            end
         end
         ABORT: begin
            state_d   = IDLE;
            to_flag_d = 1'b1;
            if (to_cnt_q != 8'hFF) to_cnt_d = to_cnt_q + 8'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus outputs: mirror the owner in BUSY, force err to the owner in ABORT.
   always_comb begin
      gnt    = 2'b00;
      s_adr  = 32'd0;
      s_dout = 8'd0;
      s_cyc  = 1'b0;
      s_stb  = 1'b0;
      s_we   = 1'b0;
      s_sel  = 1'b0;
      m0_din = s_din;
      m1_din = s_din;
      m0_ack = 1'b0;
      m0_err = 1'b0;
      m0_rty = 1'b0;
      m1_ack = 1'b0;
      m1_err = 1'b0;
      m1_rty = 1'b0;
      case (state_q)
         BUSY0, BUSY1: begin
            gnt    = last_q ? 2'b10 : 2'b01;
            s_adr  = g_adr;
            s_dout = g_dout;
            s_cyc  = g_cyc;
            s_stb  = g_stb;
            s_we   = g_we;
            s_sel  = g_sel;
            if (last_q) begin
               m1_ack = s_ack;
               m1_err = s_err;
               m1_rty = s_rty;
            end else begin
               m0_ack = s_ack;
               m0_err = s_err;
               m0_rty = s_rty;
            end
         end
         ABORT: begin
            gnt = last_q ? 2'b10 : 2'b01;
            if (last_q) m1_err = 1'b1;
            else        m0_err = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
